bf_exec_core: RTL

- Parametrised Brainfuck execution core; successor to the fixed-width processor under the `tt_um_loco_choco` top.
- Fetches ASCII program bytes from an external program memory over a req/valid handshake.
- Executes them against an internal tape with configurable cell width, tape depth and loop-nesting depth.
- Exchanges '.'/',' data over valid/ready streams. Sits between the top-level pin mux and the program-store/IO adapters.

---
 rtl/bf_exec_core_if.sv | 28 ++
 rtl/bf_exec_core.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bf_exec_core_if.sv
// bf_exec_core_if: program-fetch, output/input streams and status of the Brainfuck core.
interface bf_exec_core_if #(
    parameter int CELL_W = 8,
    parameter int PC_W   = 8
);
    logic              start;
    logic              instr_req;
    logic [PC_W-1:0]   instr_addr;
    logic              instr_valid;
    logic [7:0]        instr_data;
    logic              out_valid;
    logic              out_ready;
    logic [CELL_W-1:0] out_data;
    logic              in_valid;
    logic              in_ready;
    logic [CELL_W-1:0] in_data;
    logic              busy;
    logic              halted;
    logic              error;
    modport slave (
        input  start, instr_valid, instr_data, out_ready, in_valid, in_data,
        output instr_req, instr_addr, out_valid, out_data, in_ready, busy, halted, error
    );
    modport master (
        output start, instr_valid, instr_data, out_ready, in_valid, in_data,
        input  instr_req, instr_addr, out_valid, out_data, in_ready, busy, halted, error
    );
endinterface

// File: rtl/bf_exec_core.sv
// bf_exec_core: Brainfuck interpreter core with fetch handshake, internal tape and loop stack.
module bf_exec_core #(
    parameter int CELL_W      = 8,
    parameter int TAPE_DEPTH  = 16,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 8
) (
    input logic          clk,
    input logic          rst,
    bf_exec_core_if.slave bus
);
    localparam int PTR_W = $clog2(TAPE_DEPTH);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_SKIP, S_OUT_WAIT, S_IN_WAIT, S_HALT, S_ERROR
    } state_t;

    state_t            r_state, w_next, w_adv;
    logic [PC_W-1:0]   r_pc;
    logic [PTR_W-1:0]  r_ptr;
    logic [CELL_W-1:0] r_tape [TAPE_DEPTH];
    logic [PC_W-1:0]   r_stack [1 << SP_W];
    logic [SP_W-1:0]   r_sp;
    logic [PC_W:0]     r_skip;
    logic [7:0]        r_instr;
    logic [CELL_W-1:0] w_cell;
    logic [PC_W:0]     w_pc_inc, w_jmp;
    logic              w_idle, w_clear, w_full, w_jump;

    assign w_cell   = r_tape[r_ptr];
    assign w_pc_inc = {1'b0, r_pc} + 1'b1;
    assign w_jmp    = {1'b0, r_stack[r_sp - 1'b1]} + 1'b1;
    assign w_idle   = r_state inside {S_IDLE, S_HALT, S_ERROR};
    assign w_clear  = w_idle && bus.start;
    assign w_full   = r_sp == SP_W'(STACK_DEPTH);
    assign w_jump   = r_instr == 8'h5D && w_cell != '0;
    // Carry out of the PC increment means the program ran off the end of memory.
    assign w_adv    = w_pc_inc[PC_W] ? S_HALT : S_FETCH;

    always_ff @(posedge clk)
        r_state <= rst ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT, S_ERROR: w_next = bus.start ? S_FETCH : r_state;
            S_FETCH: w_next = bus.instr_valid ? (r_skip != '0 ? S_SKIP : S_EXEC) : S_FETCH;
            S_EXEC: begin
                case (r_instr)
                    8'h2E:   w_next = S_OUT_WAIT;
                    8'h2C:   w_next = S_IN_WAIT;
                    8'h00:   w_next = S_HALT;
                    8'h5B:   w_next = (w_cell != '0 && w_full) ? S_ERROR : w_adv;
                    8'h5D:   w_next = r_sp == '0 ? S_ERROR : w_jump ? (w_jmp[PC_W] ? S_HALT : S_FETCH) : w_adv;
                    default: w_next = w_adv;
                endcase
            end
            S_SKIP:     w_next = r_instr == 8'h00 ? S_ERROR : w_adv;
            S_OUT_WAIT: w_next = bus.out_ready ? w_adv : r_state;
            S_IN_WAIT:  w_next = bus.in_valid ? w_adv : r_state;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_pc    <= '0;
            r_ptr   <= '0;
            r_sp    <= '0;
            r_skip  <= '0;
            r_instr <= '0;
            for (int i = 0; i < TAPE_DEPTH; i++) r_tape[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (bus.instr_valid) r_instr <= bus.instr_data;
                S_EXEC: begin
                    case (r_instr)
                        8'h2B: r_tape[r_ptr] <= w_cell + 1'b1;
                        8'h2D: r_tape[r_ptr] <= w_cell - 1'b1;
                        8'h3E: r_ptr <= r_ptr + 1'b1;
                        8'h3C: r_ptr <= r_ptr - 1'b1;
                        8'h5B: begin
                            if (w_cell == '0) r_skip <= 1;
                            else if (!w_full) begin
                                r_stack[r_sp] <= r_pc;
                                r_sp          <= r_sp + 1'b1;
                            end
                        end
                        8'h5D: if (r_sp != '0 && w_cell == '0) r_sp <= r_sp - 1'b1;
                        default: ;
                    endcase
                    // I/O advances the PC on completion; 0x00 leaves it where it halted.
                    if (!(r_instr inside {8'h2E, 8'h2C, 8'h00}))
                        r_pc <= w_jump ? w_jmp[PC_W-1:0] : w_pc_inc[PC_W-1:0];
                end
                S_SKIP: begin
                    r_skip <= r_instr == 8'h5B ? r_skip + 1'b1 : r_instr == 8'h5D ? r_skip - 1'b1 : r_skip;
                    r_pc   <= w_pc_inc[PC_W-1:0];
                end
                S_OUT_WAIT: if (bus.out_ready) r_pc <= w_pc_inc[PC_W-1:0];
                S_IN_WAIT: begin
                    if (bus.in_valid) begin
                        r_tape[r_ptr] <= bus.in_data;
                        r_pc          <= w_pc_inc[PC_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_req  = r_state == S_FETCH;
    assign bus.instr_addr = r_pc;
    assign bus.out_valid  = r_state == S_OUT_WAIT;
    assign bus.out_data   = bus.out_valid ? w_cell : '0;
    assign bus.in_ready   = r_state == S_IN_WAIT;
    assign bus.busy       = !w_idle;
    assign bus.halted     = r_state == S_HALT;
    assign bus.error      = r_state == S_ERROR;
endmodule
